// File: rtl/divider.sv
// divider: sequential 32-bit unsigned restoring divider, one quotient bit per clock, result {remainder, quotient}
// Ports: clk; reset (async, active-low); Signal (function field, 6'b011011 = DIVU starts);
//   dividend/divisor (sampled on the start edge); dataout {rem, quo}; busy (RUN);
//   done (one-cycle pulse with new dataout); div_zero (last completed divide had divisor 0)
module divider (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Signal,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [63:0] dataout,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  localparam logic [5:0] DIVU = 6'b011011;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic [5:0]  count;
  logic        armed;
  logic [32:0] t;
  logic [31:0] diff;
  logic        fits;
  // A fitting partial remainder minus dvsr is always below 2^32, so 32-bit subtraction is exact.
  always_comb begin
    t = {rem, quo[31]};
    fits = t >= {1'b0, dvsr};
    diff = t[31:0] - dvsr;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rem <= '0;
      quo <= '0;
      dvsr <= '0;
      count <= '0;
      armed <= 1'b1;
      dataout <= '0;
      div_zero <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      // Re-arm whenever the start code is absent so a held DIVU yields one operation.
      if (Signal != DIVU) armed <= 1'b1;
      case (state)
        IDLE: if (Signal == DIVU && armed) begin
          rem <= '0;
          quo <= dividend;
          dvsr <= divisor;
          count <= 6'd32;
          armed <= 1'b0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          rem <= fits ? diff : t[31:0];
          quo <= {quo[30:0], fits};
          count <= count - 6'd1;
          if (count == 6'd1) begin
            busy <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          dataout <= {rem, quo};
          div_zero <= dvsr == '0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
